frame_loader: RTL and testbench

Upstream framing stage between the UART receiver and `net_proc`. It turns `uart_rx` byte-ready levels into a 784-byte image frame and drives `net_proc`'s external-memory write port and start pulse. It waits for the network's `done`, then emits the ASCII result request for `uart_tx`. It replaces the ad-hoc counter and edge-detect glue in the top level with one FSM that has overrun and timeout handling.

---
 rtl/frame_loader.sv | 173 +++++++++++++++++
 tb/tb_frame_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_loader.sv
// Frame loader: turns UART byte-ready edges into one image frame for net_proc,
// starts the network, then issues the ASCII result. Optional FRAME_TIMEOUT_EN discards stale partial frames.
module frame_loader #(
  parameter int FRAME_BYTES    = 784,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       ext_mem_rst,
  output logic       ext_mem_we,
  output logic [7:0] ext_mem_wdata,
  output logic       start,
  input  logic       done,
  input  logic [3:0] max_idx,
  output logic       tx_rq,
  output logic [7:0] tx_data,
  output logic       overrun,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for the first byte of a frame
  // LOAD  | accepting bytes until the frame is complete
  // START | two cycles: let the last write land, then pulse start
  // BUSY  | network running; wait for the rising edge of done
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_BUSY} state_t;

  localparam logic [9:0] LAST_COUNT = 10'(FRAME_BYTES);

  state_t     state, state_nx;
  logic [9:0] count, count_nx;
  logic       rx_ready_q, done_q;
  logic       byte_ev, done_rise;
  logic       cap_vld, cap_vld_nx;
  logic [7:0] cap_data, cap_data_nx;
  logic       drain, drain_nx;
  logic       ext_mem_rst_nx, start_nx, tx_rq_nx, overrun_nx, busy_nx;
  logic [7:0] tx_data_nx;
  logic       timeout_hit;

  assign byte_ev   = rx_ready && !rx_ready_q;
  assign done_rise = done && !done_q;

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IDLE_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_cnt;

  // Down-counter reloaded on every byte; terminal count means the frame went stale.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      idle_cnt <= IDLE_LOAD;
    end else if (byte_ev || state != S_LOAD) begin
      idle_cnt <= IDLE_LOAD;
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

  assign timeout_hit = (idle_cnt == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nx       = state;
    count_nx       = count;
    cap_vld_nx     = 1'b0;
    cap_data_nx    = cap_data;
    drain_nx       = 1'b0;
    ext_mem_rst_nx = 1'b0;
    start_nx       = 1'b0;
    tx_rq_nx       = 1'b0;
    tx_data_nx     = tx_data;
    overrun_nx     = overrun;

    case (state)
      S_IDLE: begin
        if (byte_ev) begin
          ext_mem_rst_nx = 1'b1;
          overrun_nx     = 1'b0;
          cap_vld_nx     = 1'b1;
          cap_data_nx    = rx_data;
          count_nx       = 10'd1;
          state_nx       = S_LOAD;
        end
      end
      S_LOAD: begin
        if (byte_ev) begin
          cap_vld_nx  = 1'b1;
          cap_data_nx = rx_data;
          count_nx    = count + 10'd1;
          if (count + 10'd1 == LAST_COUNT) begin
            state_nx = S_START;
          end
        end else if (timeout_hit) begin
          count_nx = '0;
          state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (byte_ev) begin
          overrun_nx = 1'b1;
        end
        if (!drain) begin
          drain_nx = 1'b1;
        end else begin
          start_nx = 1'b1;
          state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        if (byte_ev) begin
          overrun_nx = 1'b1;
        end
        if (done_rise) begin
          tx_data_nx = 8'h30 + {4'h0, max_idx};
          tx_rq_nx   = 1'b1;
          count_nx   = '0;
          state_nx   = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    busy_nx = (state_nx == S_START) || (state_nx == S_BUSY);
  end

  // Captured byte is written one cycle later, so the pointer reset never collides with a write.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state         <= S_IDLE;
      count         <= '0;
      rx_ready_q    <= 1'b1;
      done_q        <= 1'b0;
      cap_vld       <= 1'b0;
      cap_data      <= 8'h00;
      drain         <= 1'b0;
      ext_mem_rst   <= 1'b0;
      ext_mem_we    <= 1'b0;
      ext_mem_wdata <= 8'h00;
      start         <= 1'b0;
      tx_rq         <= 1'b0;
      tx_data       <= 8'h3F;
      overrun       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      rx_ready_q  <= rx_ready;
      done_q      <= done;
      cap_vld     <= cap_vld_nx;
      cap_data    <= cap_data_nx;
      drain       <= drain_nx;
      ext_mem_rst <= ext_mem_rst_nx;
      ext_mem_we  <= cap_vld;
      if (cap_vld) begin
        ext_mem_wdata <= cap_data;
      end
      start       <= start_nx;
      tx_rq       <= tx_rq_nx;
      tx_data     <= tx_data_nx;
      overrun     <= overrun_nx;
      busy        <= busy_nx;
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: randomized bytes scored against a frame-level model.
module tb_frame_loader;
  localparam int FB = 784;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       nRST;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       ext_mem_rst;
  logic       ext_mem_we;
  logic [7:0] ext_mem_wdata;
  logic       start;
  logic       done;
  logic [3:0] max_idx;
  logic       tx_rq;
  logic [7:0] tx_data;
  logic       overrun;
  logic       busy;

  frame_loader #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .nRST(nRST), .rx_ready(rx_ready), .rx_data(rx_data),
    .ext_mem_rst(ext_mem_rst), .ext_mem_we(ext_mem_we), .ext_mem_wdata(ext_mem_wdata),
    .start(start), .done(done), .max_idx(max_idx), .tx_rq(tx_rq), .tx_data(tx_data),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle.
  int         mon_rst = 0, mon_we = 0, mon_both = 0, mon_start = 0, mon_tx = 0;
  int         mon_start_cyc = -1, mon_tx_cyc = -1, mon_busy_cyc = -1;
  logic       busy_prev = 1'b0;
  logic [7:0] act_q[$];

  always @(negedge clk) begin
    if (nRST === 1'b1) begin
      if (ext_mem_rst) mon_rst++;
      if (ext_mem_we) begin
        mon_we++;
        act_q.push_back(ext_mem_wdata);
      end
      if (ext_mem_rst && ext_mem_we) mon_both++;
      if (start) begin
        mon_start++;
        mon_start_cyc = cyc;
      end
      if (tx_rq) begin
        mon_tx++;
        mon_tx_cyc = cyc;
      end
      if (busy && !busy_prev) mon_busy_cyc = cyc;
      busy_prev = busy;
    end
  end

  // Frame-level reference model.
  int         m_count = 0;
  bit         m_wait = 0;
  bit         exp_ovr = 0;
  logic [7:0] exp_tx_data = 8'h3F;
  logic [7:0] exp_q[$];
  int         chk_idx = 0;
  int         checks = 0, errors = 0;

  task automatic model_reset();
    m_count     = 0;
    m_wait      = 0;
    exp_ovr     = 0;
    exp_tx_data = 8'h3F;
    chk_idx     = exp_q.size();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_wait) begin
      exp_ovr = 1;
    end else begin
      if (m_count == 0) exp_ovr = 0;
      exp_q.push_back(b);
      m_count++;
      if (m_count == FB) begin
        m_wait  = 1;
        m_count = 0;
      end
    end
  endtask

  task automatic model_done(input logic [3:0] idx);
    if (m_wait) begin
      m_wait      = 0;
      exp_tx_data = 8'h30 + {4'h0, idx};
    end
  endtask

  task automatic model_idle(input int n);
`ifdef FRAME_TIMEOUT_EN
    if (!m_wait && m_count > 0 && n >= TO) m_count = 0;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap, output int ev);
    rx_data  = b;
    rx_ready = 1'b1;
    ev       = cyc;
    model_byte(b);
    idle(1 + hold);
    rx_ready = 1'b0;
    idle(1 + gap);
  endtask

  task automatic drive_done(input logic [3:0] idx, output int d);
    max_idx = idx;
    done    = 1'b1;
    d       = cyc;
    model_done(idx);
    idle(1);
    done = 1'b0;
    idle(1);
  endtask

  task automatic pulse_reset();
    nRST = 1'b0;
    idle(2);
    nRST = 1'b1;
    model_reset();
    idle(2);
  endtask

  task automatic test_reset();
    rx_ready = 1'b1;
    nRST     = 1'b0;
    idle(3);
    checks++;
    if ({ext_mem_rst, ext_mem_we, ext_mem_wdata, start, tx_rq, tx_data, overrun, busy} !==
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got rst=%b we=%b wd=%h st=%b rq=%b txd=%h ovr=%b busy=%b, want 0 0 00 0 0 3f 0 0",
               ext_mem_rst, ext_mem_we, ext_mem_wdata, start, tx_rq, tx_data, overrun, busy);
    end
    nRST = 1'b1;
    model_reset();
    idle(4);
    checks++;
    if (mon_rst != 0 || mon_we != 0) begin
      errors++;
      $display("FAIL reset_high_ready: got rst=%0d we=%0d, want 0 0", mon_rst, mon_we);
    end
    rx_ready = 1'b0;
    idle(2);
  endtask

  task automatic test_nominal();
    int ev, d, r0, w0, s0, t0, bad, first;
    r0 = mon_rst; w0 = mon_we; s0 = mon_start; t0 = mon_tx;
    for (int i = 0; i < FB; i++) send_byte(8'(i), $urandom_range(0, 1), $urandom_range(0, 1), ev);
    idle(4);
    checks++;
    if (mon_rst - r0 != 1) begin errors++; $display("FAIL nominal_rst_count: got %0d want 1", mon_rst - r0); end
    checks++;
    if (mon_we - w0 != FB) begin errors++; $display("FAIL nominal_we_count: got %0d want %0d", mon_we - w0, FB); end
    bad = 0; first = -1;
    for (int i = chk_idx; i < exp_q.size(); i++)
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nominal_wdata: %0d bad, first idx %0d got %h want %h", bad, first,
               (first < act_q.size()) ? act_q[first] : 8'hxx, exp_q[first]);
    end
    chk_idx = exp_q.size();
    checks++;
    if (mon_start - s0 != 1) begin errors++; $display("FAIL nominal_start_count: got %0d want 1", mon_start - s0); end
    checks++;
    if (mon_start_cyc != ev + 3) begin errors++; $display("FAIL nominal_start_cycle: got %0d want %0d", mon_start_cyc, ev + 3); end
    checks++;
    if (mon_busy_cyc != ev + 1) begin errors++; $display("FAIL nominal_busy_cycle: got %0d want %0d", mon_busy_cyc, ev + 1); end
    drive_done(4'd7, d);
    idle(2);
    checks++;
    if (mon_tx - t0 != 1 || mon_tx_cyc != d + 1) begin
      errors++;
      $display("FAIL nominal_tx_rq: got count %0d cycle %0d want 1 at %0d", mon_tx - t0, mon_tx_cyc, d + 1);
    end
    checks++;
    if (tx_data !== 8'h37) begin errors++; $display("FAIL nominal_tx_data: got %h want 37", tx_data); end
  endtask

  task automatic test_overrun();
    int ev, d, w0, r0;
    for (int i = 0; i < FB; i++) send_byte(8'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), ev);
    idle(4);
    w0 = mon_we;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0, 1, ev);
    idle(3);
    checks++;
    if (mon_we != w0) begin errors++; $display("FAIL overrun_no_write: got %0d writes want 0", mon_we - w0); end
    checks++;
    if (overrun !== exp_ovr || exp_ovr !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    drive_done(4'($urandom_range(0, 9)), d);
    idle(3);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    checks++;
    if (tx_data !== exp_tx_data) begin errors++; $display("FAIL overrun_tx_data: got %h want %h", tx_data, exp_tx_data); end
    r0 = mon_rst;
    send_byte(8'($urandom), 0, 1, ev);
    idle(1);
    checks++;
    if (overrun !== exp_ovr || mon_rst != r0 + 1) begin
      errors++;
      $display("FAIL overrun_clear: got ovr=%b rst=%0d want ovr=0 rst=1", overrun, mon_rst - r0);
    end
  endtask

  task automatic test_mid_reset();
    int ev, r0, s0, bad;
    for (int i = 0; i < 399; i++) send_byte(8'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), ev);
    idle(4);
    bad = 0;
    for (int i = chk_idx; i < exp_q.size(); i++)
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midreset_wdata: got %0d bad, %0d writes want 0 bad, %0d writes", bad, act_q.size(), exp_q.size());
    end
    r0 = mon_rst; s0 = mon_start;
    nRST = 1'b0;
    #1;
    checks++;
    if ({ext_mem_rst, ext_mem_we, ext_mem_wdata, start, tx_rq, tx_data, overrun, busy} !==
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_outputs: got we=%b wd=%h txd=%h ovr=%b busy=%b want 0 00 3f 0 0",
               ext_mem_we, ext_mem_wdata, tx_data, overrun, busy);
    end
    idle(2);
    nRST = 1'b1;
    model_reset();
    idle(2);
    for (int i = 0; i < FB - 1; i++) send_byte(8'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), ev);
    idle(4);
    checks++;
    if (mon_start != s0 || mon_rst != r0 + 1) begin
      errors++;
      $display("FAIL midreset_partial: got start=%0d rst=%0d want 0 1", mon_start - s0, mon_rst - r0);
    end
    send_byte(8'($urandom), 0, 0, ev);
    idle(3);
    checks++;
    if (mon_start != s0 + 1 || mon_start_cyc != ev + 3) begin
      errors++;
      $display("FAIL midreset_start: got %0d at %0d want 1 at %0d", mon_start - s0, mon_start_cyc, ev + 3);
    end
  endtask

  task automatic test_stray_done();
    int ev, d, t0;
    logic [3:0] idx;
    pulse_reset();
    t0 = mon_tx;
    drive_done(4'($urandom_range(0, 9)), d);
    idle(2);
    checks++;
    if (mon_tx != t0 || tx_data !== 8'h3F) begin
      errors++;
      $display("FAIL stray_idle: got rq=%0d txd=%h want 0 3f", mon_tx - t0, tx_data);
    end
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0, 1, ev);
    drive_done(4'($urandom_range(0, 9)), d);
    idle(2);
    checks++;
    if (mon_tx != t0 || tx_data !== 8'h3F) begin
      errors++;
      $display("FAIL stray_load: got rq=%0d txd=%h want 0 3f", mon_tx - t0, tx_data);
    end
    for (int i = 5; i < FB; i++) send_byte(8'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), ev);
    idle(4);
    idx = 4'($urandom_range(0, 9));
    drive_done(idx, d);
    idle(2);
    checks++;
    if (mon_tx != t0 + 1 || mon_tx_cyc != d + 1 || tx_data !== exp_tx_data) begin
      errors++;
      $display("FAIL stray_busy_done: got rq=%0d at %0d txd=%h want 1 at %0d txd=%h",
               mon_tx - t0, mon_tx_cyc, tx_data, d + 1, exp_tx_data);
    end
  endtask

  task automatic test_timeout();
    int ev, d, r0, s0, k, exp_rst_d;
    int evs[FB];
    r0 = mon_rst; s0 = mon_start;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0, 1, ev);
    model_idle(TO + 20);
    idle(TO + 20);
    for (int i = 0; i < FB; i++) begin
      send_byte(8'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), ev);
      evs[i] = ev;
    end
    idle(4);
`ifdef FRAME_TIMEOUT_EN
    k = FB; exp_rst_d = 2;
`else
    k = FB - 10; exp_rst_d = 1;
`endif
    checks++;
    if (mon_rst - r0 != exp_rst_d) begin errors++; $display("FAIL timeout_rst_count: got %0d want %0d", mon_rst - r0, exp_rst_d); end
    checks++;
    if (mon_start - s0 != 1 || mon_start_cyc != evs[k-1] + 3) begin
      errors++;
      $display("FAIL timeout_start: got %0d at %0d want 1 at %0d", mon_start - s0, mon_start_cyc, evs[k-1] + 3);
    end
    checks++;
    if (overrun !== exp_ovr) begin errors++; $display("FAIL timeout_overrun: got %b want %b", overrun, exp_ovr); end
    drive_done(4'($urandom_range(0, 9)), d);
    idle(2);
    checks++;
    if (tx_data !== exp_tx_data) begin errors++; $display("FAIL timeout_tx_data: got %h want %h", tx_data, exp_tx_data); end
  endtask

  task automatic test_back_to_back();
    int ev, w0, r0, bad, first;
    w0 = mon_we; r0 = mon_rst;
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 0, 0, ev);
    send_byte(8'($urandom), 3, 0, ev);
    idle(4);
    checks++;
    if (mon_we - w0 != 21) begin errors++; $display("FAIL b2b_we_count: got %0d want 21", mon_we - w0); end
    checks++;
    if (mon_rst - r0 != 1) begin errors++; $display("FAIL b2b_rst_count: got %0d want 1", mon_rst - r0); end
    bad = 0; first = -1;
    for (int i = chk_idx; i < exp_q.size(); i++)
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0 || act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_wdata: got %0d bad of %0d writes want 0 bad of %0d", bad, act_q.size(), exp_q.size());
    end
    chk_idx = exp_q.size();
    checks++;
    if (mon_both != 0) begin errors++; $display("FAIL rst_we_overlap: got %0d want 0", mon_both); end
  endtask

  initial begin
    nRST     = 1'b0;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
    done     = 1'b0;
    max_idx  = 4'h0;
    idle(1);
    test_reset();
    test_nominal();
    test_overrun();
    test_mid_reset();
    test_stray_done();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
